// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one data-memory bus between instruction fetch (port 0, read-only)
// and the load/store unit (port 1, read/write). One transaction at a time,
// round-robin on contention, registered downstream command, combinational
// done/readdata steering back to the owner, and a watchdog that turns a
// hung bus cycle into an error completion.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [1:0]  FETCH_SIZE     = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  // port 0: instruction fetch
  input  logic [63:0] p0_address,
  input  logic        p0_read,
  output logic [63:0] p0_readdata,
  output logic        p0_done,
  output logic        p0_err,
  // port 1: load/store unit
  input  logic [63:0] p1_address,
  input  logic [1:0]  p1_datasize,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [63:0] p1_writedata,
  output logic [63:0] p1_readdata,
  output logic        p1_done,
  output logic        p1_err,
  // downstream memory bus
  output logic [63:0] m_address,
  output logic [1:0]  m_datasize,
  output logic        m_read,
  output logic        m_write,
  output logic [63:0] m_writedata,
  input  logic [63:0] m_readdata,
  input  logic        m_done,
  // status
  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_e;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WD_LAST_INT = (TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0;
  localparam logic [CW-1:0] WD_LAST = WD_LAST_INT[CW-1:0];
  localparam logic          WD_ON   = (TIMEOUT_CYCLES != 32'd0);

  state_e        state_q, state_d;
  logic          last_q, last_d;       // 0: port 0 served last, 1: port 1
  logic          m_read_q, m_read_d;
  logic          m_write_q, m_write_d;
  logic [63:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [CW-1:0] wd_q, wd_d;

  logic          req0_s, req1_s, pick1_s, wd_expire_s;

  // State, command and watchdog registers; async reset drops strobes at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      addr_q    <= 64'd0;
      size_q    <= 2'd0;
      wdata_q   <= 64'd0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wd_q      <= wd_d;
    end
  end

  // Arbitration, next-state and owner completion steering.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    m_read_d    = m_read_q;
    m_write_d   = m_write_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wd_d        = wd_q;
    p0_done     = 1'b0;
    p0_err      = 1'b0;
    p0_readdata = 64'd0;
    p1_done     = 1'b0;
    p1_err      = 1'b0;
    p1_readdata = 64'd0;

    req0_s      = p0_read;
    req1_s      = p1_read | p1_write;
    // On contention the port that was not served last wins.
    pick1_s     = req1_s & (~req0_s | ~last_q);
    wd_expire_s = WD_ON & (wd_q == WD_LAST);

    case (state_q)
      S_IDLE: begin
        if (pick1_s) begin
          state_d   = S_GRANT1;
          addr_d    = p1_address;
          size_d    = p1_datasize;
          wdata_d   = p1_writedata;
          m_write_d = p1_write;          // write beats a simultaneous read
          m_read_d  = ~p1_write;
          wd_d      = '0;
        end else if (req0_s) begin
          state_d   = S_GRANT0;
          addr_d    = p0_address;
          size_d    = FETCH_SIZE;
          m_write_d = 1'b0;
          m_read_d  = 1'b1;
          wd_d      = '0;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_GRANT0: begin
        if (m_done) begin
          p0_done     = 1'b1;
          p0_readdata = m_readdata;
          state_d     = S_IDLE;
          m_read_d    = 1'b0;
          m_write_d   = 1'b0;
          last_d      = 1'b0;
        end else if (wd_expire_s) begin
          p0_done     = 1'b1;
          p0_err      = 1'b1;
          state_d     = S_IDLE;
          m_read_d    = 1'b0;
          m_write_d   = 1'b0;
          last_d      = 1'b0;
        end else begin
          wd_d        = wd_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      S_GRANT1: begin
        if (m_done) begin
          p1_done     = 1'b1;
          p1_readdata = m_readdata;
          state_d     = S_IDLE;
          m_read_d    = 1'b0;
          m_write_d   = 1'b0;
          last_d      = 1'b1;
        end else if (wd_expire_s) begin
          p1_done     = 1'b1;
          p1_err      = 1'b1;
          state_d     = S_IDLE;
          m_read_d    = 1'b0;
          m_write_d   = 1'b0;
          last_d      = 1'b1;
        end else begin
          wd_d        = wd_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d   = S_IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  assign m_address   = addr_q;
  assign m_datasize  = size_q;
  assign m_writedata = wdata_q;
  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign busy        = (state_q == S_GRANT0) || (state_q == S_GRANT1);
  assign grant       = {(state_q == S_GRANT1), (state_q == S_GRANT0)};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an expected-transaction scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] p0_address;
  logic        p0_read;
  logic [63:0] p0_readdata;
  logic        p0_done, p0_err;
  logic [63:0] p1_address;
  logic [1:0]  p1_datasize;
  logic        p1_read, p1_write;
  logic [63:0] p1_writedata;
  logic [63:0] p1_readdata;
  logic        p1_done, p1_err;
  logic [63:0] m_address;
  logic [1:0]  m_datasize;
  logic        m_read, m_write;
  logic [63:0] m_writedata;
  logic [63:0] m_readdata;
  logic        m_done;
  logic        busy;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  gnt;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        rd;
    logic        wr;
    logic [63:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  mem_port_arbiter #(.TIMEOUT_CYCLES(8), .FETCH_SIZE(2'b10)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_read(p0_read), .p0_readdata(p0_readdata),
    .p0_done(p0_done), .p0_err(p0_err),
    .p1_address(p1_address), .p1_datasize(p1_datasize), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_readdata(p1_readdata),
    .p1_done(p1_done), .p1_err(p1_err),
    .m_address(m_address), .m_datasize(m_datasize), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_done(m_done), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] gnt, input logic [63:0] addr, input logic [1:0] size,
                      input logic rd, input logic wr, input logic [63:0] wdata);
    exp_t e;
    e.gnt = gnt; e.addr = addr; e.size = size; e.rd = rd; e.wr = wr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic clear_req(input logic [1:0] gnt);
    if (gnt[0]) p0_read = 1'b0;
    else begin p1_read = 1'b0; p1_write = 1'b0; end
  endtask

  // Wait (bounded) for a downstream strobe, then pop and compare the command.
  task automatic start_txn(output exp_t e, output bit ok);
    int n = 0;
    ok = 1'b0;
    e.gnt = 2'd0; e.addr = 64'd0; e.size = 2'd0; e.rd = 1'b0; e.wr = 1'b0; e.wdata = 64'd0;
    do begin @(posedge clk); #1; n++; end while (!(m_read || m_write) && n < 10);
    chk("grant_latency", 64'(n), 64'd1);
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL scoreboard: observed strobe expected none");
    end else begin
      e = exp_q.pop_front();
      ok = 1'b1;
      chk("grant", 64'(grant), 64'(e.gnt));
      chk("busy_on", 64'(busy), 64'd1);
      chk("m_address", m_address, e.addr);
      chk("m_datasize", 64'(m_datasize), 64'(e.size));
      chk("m_read", 64'(m_read), 64'(e.rd));
      chk("m_write", 64'(m_write), 64'(e.wr));
      if (e.wr) chk("m_writedata", m_writedata, e.wdata);
    end
  endtask

  // Full transaction: strobe, m_done after delay cycles, owner done, idle cycle.
  task automatic serve(input int delay, input logic [63:0] rdata, input bit drop_after, input bit drop_early);
    exp_t e; bit ok;
    start_txn(e, ok);
    if (ok) begin
      if (drop_early) clear_req(e.gnt);
      for (int i = 1; i <= delay; i++) begin
        @(posedge clk); #1;
        if (i < delay) chk("strobe_held", 64'({m_read, m_write}), 64'({e.rd, e.wr}));
      end
      m_readdata = rdata; m_done = 1'b1; #1;
      chk("p0_done", 64'(p0_done), 64'(e.gnt[0]));
      chk("p1_done", 64'(p1_done), 64'(e.gnt[1]));
      chk("err", 64'({p1_err, p0_err}), 64'd0);
      if (e.rd && e.gnt[0]) chk("p0_readdata", p0_readdata, rdata);
      if (e.rd && e.gnt[1]) chk("p1_readdata", p1_readdata, rdata);
      @(posedge clk); #1;
      m_done = 1'b0; m_readdata = 64'd0;
      if (drop_after) clear_req(e.gnt);
      chk("idle_gap", 64'({busy, grant, m_read, m_write}), 64'd0);
    end
  endtask

  initial begin
    exp_t e; bit ok; int found;
    reset_n = 1'b0;
    p0_address = 64'd0; p0_read = 1'b0;
    p1_address = 64'd0; p1_datasize = 2'd0; p1_read = 1'b0; p1_write = 1'b0; p1_writedata = 64'd0;
    m_readdata = 64'd0; m_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 64'({m_read, m_write, busy, grant}), 64'd0);
    chk("rst_done", 64'({p0_done, p0_err, p1_done, p1_err}), 64'd0);
    chk("rst_m_address", m_address, 64'd0);
    chk("rst_m_writedata", m_writedata, 64'd0);
    reset_n = 1'b1;

    // Simultaneous fetch and store after reset: port 1 first, then port 0.
    p0_address = 64'h0000_0000_0000_0400; p0_read = 1'b1;
    p1_address = 64'h0000_0000_0000_2008; p1_datasize = 2'd3; p1_write = 1'b1;
    p1_writedata = 64'h1122_3344_5566_7788;
    push(2'b10, 64'h2008, 2'd3, 1'b0, 1'b1, 64'h1122_3344_5566_7788);
    push(2'b01, 64'h0400, 2'b10, 1'b1, 1'b0, 64'd0);
    serve(2, 64'd0, 1'b1, 1'b0);
    serve(3, 64'hA5A5_0000_1234_5678, 1'b1, 1'b0);

    // Continuous requests from both ports: p1,p0,p1,p0,p1,p0.
    p0_address = 64'h0000_0000_0000_0800; p0_read = 1'b1;
    p1_address = 64'h0000_0000_0000_3000; p1_datasize = 2'd1; p1_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(2'b10, 64'h3000, 2'd1, 1'b1, 1'b0, 64'd0);
      push(2'b01, 64'h0800, 2'b10, 1'b1, 1'b0, 64'd0);
    end
    for (int k = 0; k < 6; k++) serve(1 + k, 64'(k) * 64'h0101_0101, k >= 4, 1'b0);

    // Single load, m_done three cycles after m_read.
    p1_address = 64'h0000_0000_0000_1000; p1_datasize = 2'd3; p1_read = 1'b1;
    push(2'b10, 64'h1000, 2'd3, 1'b1, 1'b0, 64'd0);
    serve(3, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);

    // Read and write both high: the write is issued.
    p1_address = 64'h0000_0000_0000_1010; p1_datasize = 2'd0;
    p1_read = 1'b1; p1_write = 1'b1; p1_writedata = 64'h55;
    push(2'b10, 64'h1010, 2'd0, 1'b0, 1'b1, 64'h55);
    serve(2, 64'd0, 1'b1, 1'b0);

    // Stray m_done while idle produces no completion.
    m_done = 1'b1; #1;
    chk("idle_mdone", 64'({p0_done, p1_done, p0_err, p1_err}), 64'd0);
    @(posedge clk); #1;
    m_done = 1'b0;
    chk("idle_mdone_busy", 64'({busy, m_read, m_write}), 64'd0);

    // Fetch request dropped mid-grant still completes.
    p0_address = 64'h0000_0000_0000_0C00; p0_read = 1'b1;
    push(2'b01, 64'h0C00, 2'b10, 1'b1, 1'b0, 64'd0);
    serve(4, 64'hCAFE_F00D_0000_0002, 1'b1, 1'b1);

    // Watchdog: m_done never returns.
    p0_address = 64'h0000_0000_0000_0F00; p0_read = 1'b1;
    push(2'b01, 64'h0F00, 2'b10, 1'b1, 1'b0, 64'd0);
    start_txn(e, ok);
    found = -1;
    for (int k = 0; k < 20; k++) begin
      if (p0_done) begin found = k; break; end
      @(posedge clk); #1;
    end
    chk("timeout_cycle", 64'(found), 64'd7);
    chk("timeout_err", 64'({p0_done, p0_err}), 64'd3);
    chk("timeout_rdata", p0_readdata, 64'd0);
    chk("timeout_p1", 64'(p1_done), 64'd0);
    p0_read = 1'b0;
    @(posedge clk); #1;
    chk("timeout_idle", 64'({busy, m_read}), 64'd0);

    // m_done in the watchdog's final cycle wins.
    p1_address = 64'h0000_0000_0000_1F00; p1_datasize = 2'd2; p1_read = 1'b1;
    push(2'b10, 64'h1F00, 2'd2, 1'b1, 1'b0, 64'd0);
    serve(7, 64'h0BAD_F00D_0000_0007, 1'b1, 1'b0);

    // Async reset mid-grant, then a fresh request.
    p1_address = 64'h0000_0000_0000_2200; p1_datasize = 2'd3; p1_read = 1'b1;
    push(2'b10, 64'h2200, 2'd3, 1'b1, 1'b0, 64'd0);
    start_txn(e, ok);
    @(posedge clk); #3;
    reset_n = 1'b0; #1;
    chk("arst_strobe", 64'({m_read, m_write, busy, grant}), 64'd0);
    chk("arst_nodone", 64'({p1_done, p0_done}), 64'd0);
    p1_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", 64'({m_read, m_write, busy}), 64'd0);
    p0_address = 64'h0000_0000_0000_0040; p0_read = 1'b1;
    push(2'b01, 64'h0040, 2'b10, 1'b1, 1'b0, 64'd0);
    serve(2, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
